// File: rtl/hazard_ctrl_unit.sv
// hazard_ctrl_unit
//   Pipeline hazard controller for the 5-stage core. It detects control
//   hazards (taken branch / jump resolved in EX) and load-use data hazards,
//   and drives the stall, bubble and flush controls for PC, IF/ID and ID/EX.
//   A small FSM stretches flushes to FLUSH_CYCLES and stalls to
//   LOAD_STALL_CYCLES. The detection cycle itself is combinational (Mealy),
//   so there is no added latency.
//
//   Optional feature macro: HAZARD_PERF_CNT_EN
//     When defined, the stall_cnt and flush_cnt saturating event counters
//     are present.
//
// Ports
//   clk, rst        clock; asynchronous active-high reset
//   pc_sel, npc_op  taken branch / jump from EX (either one redirects)
//   id_rs1/2(_used) source registers of the instruction in ID, and whether
//                   each one is actually read
//   ex_rd           destination register of the instruction in EX
//   ex_mem_read     the instruction in EX is a load
//   stall_pc, stall_ifid, bubble_idex   load-use stall controls
//   flush_ifid, flush_idex              redirect flush controls
//   stall_cnt, flush_cnt                perf counters (macro only)
module hazard_ctrl_unit #(
    parameter int REG_ADDR_W        = 5,
    parameter int FLUSH_CYCLES      = 1,
    parameter int LOAD_STALL_CYCLES = 1,
    parameter int CNT_W             = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  pc_sel,
    input  logic                  npc_op,
    input  logic [REG_ADDR_W-1:0] id_rs1,
    input  logic [REG_ADDR_W-1:0] id_rs2,
    input  logic                  id_rs1_used,
    input  logic                  id_rs2_used,
    input  logic [REG_ADDR_W-1:0] ex_rd,
    input  logic                  ex_mem_read,
    output logic                  stall_pc,
    output logic                  stall_ifid,
    output logic                  bubble_idex,
    output logic                  flush_ifid,
    output logic                  flush_idex
`ifdef HAZARD_PERF_CNT_EN
    ,
    output logic [CNT_W-1:0]      stall_cnt,
    output logic [CNT_W-1:0]      flush_cnt
`endif
);

    localparam int MAX_CYC = (FLUSH_CYCLES > LOAD_STALL_CYCLES) ? FLUSH_CYCLES
                                                                 : LOAD_STALL_CYCLES;
    localparam int REM_W = $clog2(MAX_CYC + 1);
    localparam logic [REM_W-1:0] FL_RELOAD = REM_W'(FLUSH_CYCLES - 1);
    localparam logic [REM_W-1:0] ST_RELOAD = REM_W'(LOAD_STALL_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        STALL = 2'd1,
        FLUSH = 2'd2
    } state_t;

    state_t           state, state_n;
    logic [REM_W-1:0] rem, rem_n;
    logic             redirect;
    logic             load_use;

    assign redirect = pc_sel | npc_op;
    assign load_use = ex_mem_read && (ex_rd != '0) &&
                      ((id_rs1_used && (id_rs1 == ex_rd)) ||
                       (id_rs2_used && (id_rs2 == ex_rd)));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            rem   <= '0;
        end else begin
            state <= state_n;
            rem   <= rem_n;
        end
    end

    always_comb begin
        state_n     = state;
        rem_n       = rem;
        stall_pc    = 1'b0;
        stall_ifid  = 1'b0;
        bubble_idex = 1'b0;
        flush_ifid  = 1'b0;
        flush_idex  = 1'b0;

        // A redirect always wins and restarts the flush window from any
        // state; a single-cycle flush needs no extension state.
        if (redirect) begin
            flush_ifid = 1'b1;
            flush_idex = 1'b1;
            if (FLUSH_CYCLES > 1) begin
                state_n = FLUSH;
                rem_n   = FL_RELOAD;
            end else begin
                state_n = IDLE;
                rem_n   = '0;
            end
        end else begin
            case (state)
                IDLE: begin
                    if (load_use) begin
                        stall_pc    = 1'b1;
                        stall_ifid  = 1'b1;
                        bubble_idex = 1'b1;
                        if (LOAD_STALL_CYCLES > 1) begin
                            state_n = STALL;
                            rem_n   = ST_RELOAD;
                        end
                    end
                end
                // load_use is not re-evaluated here: the same load/consumer
                // pair is still sitting in EX/ID while the pipe is held.
                STALL: begin
                    stall_pc    = 1'b1;
                    stall_ifid  = 1'b1;
                    bubble_idex = 1'b1;
                    rem_n       = rem - REM_W'(1);
                    if (rem <= REM_W'(1)) state_n = IDLE;
                end
                // ID contents are being discarded, so load_use is ignored.
                FLUSH: begin
                    flush_ifid = 1'b1;
                    rem_n      = rem - REM_W'(1);
                    if (rem <= REM_W'(1)) state_n = IDLE;
                end
                default: begin
                    state_n = IDLE;
                    rem_n   = '0;
                end
            endcase
        end

        // Outputs drop immediately while reset is held, even if an EX
        // redirect or load-use pattern happens to be present.
        if (rst) begin
            stall_pc    = 1'b0;
            stall_ifid  = 1'b0;
            bubble_idex = 1'b0;
            flush_ifid  = 1'b0;
            flush_idex  = 1'b0;
        end
    end

`ifdef HAZARD_PERF_CNT_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else begin
            if (stall_pc && (stall_cnt != '1)) stall_cnt <= stall_cnt + CNT_W'(1);
            if (flush_idex && (flush_cnt != '1)) flush_cnt <= flush_cnt + CNT_W'(1);
        end
    end
`endif

endmodule

// File: tb/tb_hazard_ctrl_unit.sv
module tb_hazard_ctrl_unit;
    localparam int W = 5;

    logic         clk = 1'b0;
    logic         rst;
    logic         pc_sel, npc_op, id_rs1_used, id_rs2_used, ex_mem_read;
    logic [W-1:0] id_rs1, id_rs2, ex_rd;

    logic a_spc, a_sif, a_bub, a_fif, a_fid;
    logic b_spc, b_sif, b_bub, b_fif, b_fid;
`ifdef HAZARD_PERF_CNT_EN
    logic [31:0] a_scnt, a_fcnt, b_scnt, b_fcnt;
`endif

    always #5 clk = ~clk;

    hazard_ctrl_unit u_a (
        .clk(clk), .rst(rst), .pc_sel(pc_sel), .npc_op(npc_op),
        .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rs1_used(id_rs1_used),
        .id_rs2_used(id_rs2_used), .ex_rd(ex_rd), .ex_mem_read(ex_mem_read),
        .stall_pc(a_spc), .stall_ifid(a_sif), .bubble_idex(a_bub),
        .flush_ifid(a_fif), .flush_idex(a_fid)
`ifdef HAZARD_PERF_CNT_EN
        , .stall_cnt(a_scnt), .flush_cnt(a_fcnt)
`endif
    );

    hazard_ctrl_unit #(.FLUSH_CYCLES(3), .LOAD_STALL_CYCLES(2)) u_b (
        .clk(clk), .rst(rst), .pc_sel(pc_sel), .npc_op(npc_op),
        .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rs1_used(id_rs1_used),
        .id_rs2_used(id_rs2_used), .ex_rd(ex_rd), .ex_mem_read(ex_mem_read),
        .stall_pc(b_spc), .stall_ifid(b_sif), .bubble_idex(b_bub),
        .flush_ifid(b_fif), .flush_idex(b_fid)
`ifdef HAZARD_PERF_CNT_EN
        , .stall_cnt(b_scnt), .flush_cnt(b_fcnt)
`endif
    );

    int n_vec = 0;
    int n_err = 0;

    // Reference model: remaining extension cycles of flush_ifid and of stall
    // per configuration, plus event tallies. Index 0 = u_a, 1 = u_b.
    int fc[2]  = '{1, 3};
    int lsc[2] = '{1, 2};
    int fl[2], sl[2];
    longint scnt[2], fcnt[2];

    function automatic logic lu_now();
        return ex_mem_read && (ex_rd != 0) &&
               ((id_rs1_used && id_rs1 == ex_rd) || (id_rs2_used && id_rs2 == ex_rd));
    endfunction

    // {stall_pc, stall_ifid, bubble_idex, flush_ifid, flush_idex}
    function automatic logic [4:0] exp_out(int k);
        if (rst) return 5'b00000;
        if (pc_sel || npc_op) return 5'b00011;
        if (fl[k] > 0) return 5'b00010;
        if (sl[k] > 0) return 5'b11100;
        if (lu_now()) return 5'b11100;
        return 5'b00000;
    endfunction

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            fl[k] = 0; sl[k] = 0; scnt[k] = 0; fcnt[k] = 0;
        end
    endtask

    // Advance the model across the coming rising edge.
    task automatic model_clock();
        logic [4:0] o;
        if (rst) begin
            model_reset();
            return;
        end
        for (int k = 0; k < 2; k++) begin
            o = exp_out(k);
            if (o[4]) scnt[k]++;
            if (o[0]) fcnt[k]++;
            if (pc_sel || npc_op) begin
                fl[k] = fc[k] - 1; sl[k] = 0;
            end else if (fl[k] > 0) fl[k]--;
            else if (sl[k] > 0) sl[k]--;
            else if (lu_now()) sl[k] = lsc[k] - 1;
        end
    endtask

    task automatic check();
        logic [4:0] oa, ob, ea, eb;
        oa = {a_spc, a_sif, a_bub, a_fif, a_fid};
        ob = {b_spc, b_sif, b_bub, b_fif, b_fid};
        ea = exp_out(0);
        eb = exp_out(1);
        n_vec++;
        assert (oa === ea) else begin
            n_err++;
            $error("FAIL outs_a t=%0t got %b exp %b", $time, oa, ea);
        end
        n_vec++;
        assert (ob === eb) else begin
            n_err++;
            $error("FAIL outs_b t=%0t got %b exp %b", $time, ob, eb);
        end
`ifdef HAZARD_PERF_CNT_EN
        n_vec++;
        assert (a_scnt === 32'(scnt[0]) && a_fcnt === 32'(fcnt[0])) else begin
            n_err++;
            $error("FAIL cnt_a got s=%0d f=%0d exp s=%0d f=%0d", a_scnt, a_fcnt, scnt[0], fcnt[0]);
        end
        n_vec++;
        assert (b_scnt === 32'(scnt[1]) && b_fcnt === 32'(fcnt[1])) else begin
            n_err++;
            $error("FAIL cnt_b got s=%0d f=%0d exp s=%0d f=%0d", b_scnt, b_fcnt, scnt[1], fcnt[1]);
        end
`endif
    endtask

    task automatic step(input logic ps, input logic np, input logic [W-1:0] r1,
                        input logic u1, input logic [W-1:0] r2, input logic u2,
                        input logic [W-1:0] rd, input logic mr);
        @(negedge clk);
        pc_sel = ps; npc_op = np; id_rs1 = r1; id_rs1_used = u1;
        id_rs2 = r2; id_rs2_used = u2; ex_rd = rd; ex_mem_read = mr;
        #1;
        check();
        model_clock();
    endtask

    task automatic idle();
        step(0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    initial begin
        rst = 1'b1;
        pc_sel = 0; npc_op = 0; id_rs1 = 0; id_rs2 = 0; ex_rd = 0;
        id_rs1_used = 0; id_rs2_used = 0; ex_mem_read = 0;
        model_reset();
        // reset state
        step(0, 0, 0, 0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0, 0, 0);
        @(negedge clk); rst = 1'b0;
        idle();

        // basic load-use on rs1, then released
        step(0, 0, 5, 1, 0, 0, 5, 1);
        idle(); idle();
        // ex_rd = 0 never stalls; unused rs2 match never stalls
        step(0, 0, 0, 1, 0, 1, 0, 1);
        step(0, 0, 1, 1, 7, 0, 7, 1);
        // rs2 match does stall
        step(0, 0, 1, 1, 7, 1, 7, 1);
        idle(); idle();

        // single branch pulse, then four quiet cycles
        step(1, 0, 0, 0, 0, 0, 0, 0);
        idle(); idle(); idle(); idle();
        // branch, then jump in cycle 2 extends flush_ifid
        step(1, 0, 0, 0, 0, 0, 0, 0);
        step(0, 1, 0, 0, 0, 0, 0, 0);
        idle(); idle(); idle();
        // load-use during FLUSH is ignored
        step(1, 0, 0, 0, 0, 0, 0, 0);
        step(0, 0, 3, 1, 0, 0, 3, 1);
        step(0, 0, 3, 1, 0, 0, 3, 1);
        idle();

        // load-use, then branch in the second stall cycle
        step(0, 0, 4, 1, 0, 0, 4, 1);
        step(1, 0, 4, 1, 0, 0, 4, 1);
        idle(); idle(); idle();
        // simultaneous load-use and jump
        step(0, 1, 6, 1, 0, 0, 6, 1);
        idle(); idle(); idle();

        // reset asserted mid-FLUSH drops outputs at once
        step(1, 0, 0, 0, 0, 0, 0, 0);
        @(negedge clk);
        pc_sel = 0; npc_op = 0; ex_mem_read = 0;
        rst = 1'b1;
        #1;
        check();
        model_clock();
        step(0, 0, 0, 0, 0, 0, 0, 0);
        @(negedge clk); rst = 1'b0;
        idle(); idle();

        // four consecutive stall cycles counted from reset
        for (int i = 0; i < 4; i++) step(0, 0, 9, 1, 0, 0, 9, 1);
        idle();

        // randomized traffic with small register indices for frequent matches
        for (int i = 0; i < 400; i++) begin
            step(($urandom % 7) == 0, ($urandom % 11) == 0,
                 W'($urandom % 4), 1'($urandom), W'($urandom % 4), 1'($urandom),
                 W'($urandom % 4), 1'($urandom));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
